// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// mux_scan_ctrl: holds a word on the 8:1 mux data inputs and steps the select
// with a programmable dwell. It returns the mux output as a serial bit stream.
// Revision: 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int DWELL     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  input  logic       abort,
  output logic [7:0] i_out,
  output logic [2:0] s_out,
  input  logic       y_in,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [2:0] C_S_START    = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [3:0] C_DWELL_LAST = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] i_out_q, i_out_d;
  logic [2:0] s_out_q, s_out_d;
  logic [3:0] dwell_q, dwell_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       bit_out_q, bit_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic       done_q, done_d;
  logic       accept;
  logic       sample;

  always_comb begin
    state_d     = state_q;
    i_out_d     = i_out_q;
    s_out_d     = s_out_q;
    dwell_d     = dwell_q;
    bitcnt_d    = bitcnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    load_ready  = (state_q == IDLE) && !rst && !abort;
    accept      = load_valid && load_ready;
    sample      = (dwell_q == C_DWELL_LAST);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          i_out_d  = load_data;
          s_out_d  = C_S_START;
          dwell_d  = 4'd0;
          bitcnt_d = 3'd0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        // Abort outranks the sample cycle: a partial word emits nothing.
        if (abort) begin
          dwell_d  = 4'd0;
          bitcnt_d = 3'd0;
          state_d  = IDLE;
        end else if (sample) begin
          bit_out_d   = y_in;
          bit_valid_d = 1'b1;
          dwell_d     = 4'd0;
          s_out_d     = MSB_FIRST ? (s_out_q - 3'd1) : (s_out_q + 3'd1);
          bitcnt_d    = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      i_out_q     <= 8'd0;
      s_out_q     <= 3'd0;
      dwell_q     <= 4'd0;
      bitcnt_q    <= 3'd0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_out_q     <= i_out_d;
      s_out_q     <= s_out_d;
      dwell_q     <= dwell_d;
      bitcnt_q    <= bitcnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
    end
  end

  assign i_out     = i_out_q;
  assign s_out     = s_out_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mux_scan_ctrl: two controller instances (LSB-first/dwell 1, MSB-first/
// dwell 3) checked every cycle against a timestamp-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  localparam int D0 = 1;
  localparam int D1 = 3;
  localparam bit M0 = 1'b0;
  localparam bit M1 = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv [2];
  logic       ab [2];
  logic [7:0] ld [2];
  logic       lr [2];
  logic [7:0] io [2];
  logic [2:0] so [2];
  logic       y  [2];
  logic       bo [2];
  logic       bv [2];
  logic       dn [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: accept timestamp plus expected registered outputs.
  bit         m_busy [2];
  int         m_t    [2];
  logic [7:0] m_data [2];
  logic [7:0] e_io   [2];
  logic [2:0] e_so   [2];
  logic       e_bo   [2];
  logic       e_bv   [2];
  logic       e_dn   [2];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(D0), .MSB_FIRST(M0)) u_dut0 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld[0]), .abort(ab[0]), .i_out(io[0]), .s_out(so[0]),
    .y_in(y[0]), .bit_out(bo[0]), .bit_valid(bv[0]), .done(dn[0])
  );

  mux_scan_ctrl #(.DWELL(D1), .MSB_FIRST(M1)) u_dut1 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld[1]), .abort(ab[1]), .i_out(io[1]), .s_out(so[1]),
    .y_in(y[1]), .bit_out(bo[1]), .bit_valid(bv[1]), .done(dn[1])
  );

  // The 8:1 mux itself.
  assign y[0] = io[0][so[0]];
  assign y[1] = io[1][so[1]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] pos(input bit msb, input int k);
    return msb ? 3'(7 - k) : 3'(k);
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_t[i] = 0; m_data[i] = 8'd0;
      e_io[i] = 8'd0; e_so[i] = 3'd0; e_bo[i] = 1'b0; e_bv[i] = 1'b0; e_dn[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d, rel, k;
      bit msb;
      d   = (i == 0) ? D0 : D1;
      msb = (i == 0) ? M0 : M1;

      check($sformatf("load_ready%0d", i), 32'(lr[i]), 32'(!m_busy[i] && !rst && !ab[i]));
      check($sformatf("i_out%0d", i),      32'(io[i]), 32'(e_io[i]));
      check($sformatf("s_out%0d", i),      32'(so[i]), 32'(e_so[i]));
      check($sformatf("bit_out%0d", i),    32'(bo[i]), 32'(e_bo[i]));
      check($sformatf("bit_valid%0d", i),  32'(bv[i]), 32'(e_bv[i]));
      check($sformatf("done%0d", i),       32'(dn[i]), 32'(e_dn[i]));

      e_bv[i] = 1'b0;
      e_dn[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
        e_io[i] = 8'd0; e_so[i] = 3'd0; e_bo[i] = 1'b0;
      end else if (m_busy[i]) begin
        rel = cyc - m_t[i] - 1;
        k   = rel / d;
        if (ab[i]) begin
          m_busy[i] = 1'b0;
        end else begin
          if ((rel % d) == d - 1) begin
            e_bv[i] = 1'b1;
            e_bo[i] = m_data[i][msb ? 7 - k : k];
            if (k == 7) begin
              e_dn[i]   = 1'b1;
              m_busy[i] = 1'b0;
            end
          end
          e_so[i] = pos(msb, (rel + 1) / d);
        end
      end else if (lv[i] && !ab[i]) begin
        m_busy[i] = 1'b1;
        m_t[i]    = cyc;
        m_data[i] = ld[i];
        e_io[i]   = ld[i];
        e_so[i]   = pos(msb, 0);
      end
    end
    cyc++;
  end

  // Present a word and hold it until the controller takes it.
  task automatic send(input int i, input logic [7:0] w);
    int n;
    n     = 0;
    lv[i] = 1'b1;
    ld[i] = w;
    do begin
      @(negedge clk);
      n++;
    end while (!lr[i] && n < 400);
    if (!lr[i]) check("send_timeout", 32'(lr[i]), 32'd1);
    @(posedge clk); #1;
    lv[i] = 1'b0;
  endtask

  task automatic pulse_abort(input int i);
    ab[i] = 1'b1;
    @(posedge clk); #1;
    ab[i] = 1'b0;
  endtask

  task automatic run_rand(input int i, input int d);
    for (int n = 0; n < 30; n++) begin
      send(i, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 8 * d)) @(posedge clk);
        #1;
        pulse_abort(i);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b1; ab[i] = 1'b0;
    end
    ld[0] = 8'hA5;
    ld[1] = 8'h81;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    fork
      send(0, 8'hA5);
      send(1, 8'h81);
    join

    send(0, 8'hFF);
    send(0, 8'h00);

    send(0, 8'hF0);
    repeat (3) @(posedge clk);
    #1 ab[0] = 1'b1;
    @(posedge clk); #1;
    lv[0] = 1'b1; ld[0] = 8'h3C;
    @(posedge clk); #1;
    lv[0] = 1'b0; ab[0] = 1'b0;

    send(1, 8'hFF);
    send(1, 8'h00);

    send(0, 8'h33);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      send(0, 8'h5C);
      send(1, 8'hC6);
    join

    fork
      run_rand(0, D0);
      run_rand(1, D1);
    join

    repeat (30) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
